// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// State encoding, op encodings and the default operand width.
package muldiv_seq_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed MULT (Booth radix-2) / DIV (restoring) sequencer
// producing a 64-bit HI/LOW result with a divide-by-zero flag.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             hilo_write,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    state_t state;
    state_t state_next;

    logic [5:0]       cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] opnd;
    logic             q_1;
    logic             sign_a;
    logic             sign_b;
    logic             zero_q;
    logic             last;

    logic [WIDTH:0]   mcand_x;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_mq;
    logic             booth_q1;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   div_acc;
    logic [WIDTH-1:0] div_mq;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign last = (cnt == 6'(WIDTH - 1));

    always_comb begin
        mcand_x = {opnd[WIDTH-1], opnd};
        acc_sum = acc;
        unique case ({mq[0], q_1})
            2'b01:   acc_sum = acc + mcand_x;
            2'b10:   acc_sum = acc - mcand_x;
            default: acc_sum = acc;
        endcase
        booth_acc = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        booth_mq  = {acc_sum[0], mq[WIDTH-1:1]};
        booth_q1  = mq[0];

        // Remainder fits in WIDTH bits; the extra top bit is the borrow.
        rem_sh  = {acc[WIDTH-1:0], mq[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd};
        div_acc = diff[WIDTH] ? rem_sh : diff;
        div_mq  = {mq[WIDTH-2:0], ~diff[WIDTH]};

        quo_fix = (sign_a ^ sign_b) ? -mq : mq;
        rem_fix = sign_a ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MULT) begin
                        state_next = MULT;
                    end else if (op_b == '0) begin
                        // Zero divisor skips iterations; FIX flags it.
                        state_next = FIX;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MULT:    state_next = last ? DONE : MULT;
            DIV:     state_next = last ? FIX : DIV;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            mq         <= '0;
            opnd       <= '0;
            q_1        <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            zero_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hilo_write <= 1'b0;
            result_hi  <= '0;
            result_lo  <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next == MULT) || (state_next == DIV)
                          || (state_next == FIX);
            done       <= (state_next == DONE);
            hilo_write <= ((state == MULT) && last)
                          || ((state == FIX) && !zero_q);
            div_zero   <= (state == FIX) && zero_q;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        acc    <= '0;
                        q_1    <= 1'b0;
                        zero_q <= (op == OP_DIV) && (op_b == '0);
                        if (op == OP_MULT) begin
                            opnd   <= op_a;
                            mq     <= op_b;
                            sign_a <= 1'b0;
                            sign_b <= 1'b0;
                        end else begin
                            opnd   <= mag(op_b);
                            mq     <= mag(op_a);
                            sign_a <= op_a[WIDTH-1];
                            sign_b <= op_b[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc <= booth_acc;
                    mq  <= booth_mq;
                    q_1 <= booth_q1;
                    cnt <= cnt + 6'd1;
                    if (last) begin
                        result_hi <= booth_acc[WIDTH-1:0];
                        result_lo <= booth_mq;
                    end
                end
                DIV: begin
                    acc <= div_acc;
                    mq  <= div_mq;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (!zero_q) begin
                        result_hi <= rem_fix;
                        result_lo <= quo_fix;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus
// random MULT/DIV traffic against a plain-arithmetic reference.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hilo_write;
    logic [31:0] result_hi;
    logic [31:0] result_lo;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .op_a(op_a),
        .op_b(op_b),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .hilo_write(hilo_write),
        .result_hi(result_hi),
        .result_lo(result_lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic o, input logic [31:0] a,
                         input logic [31:0] b, input string tag,
                         input bit glitch, input bit poke);
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [31:0] e_hi, e_lo;
        bit          zero;
        int          n, lat;
        zero = o && (b == 32'd0);
        e_hi = m_hi;
        e_lo = m_lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = 64'(sa * sb);
            e_hi = p[63:32];
            e_lo = p[31:0];
        end else if (!zero) begin
            q = sa / sb;
            r = sa % sb;
            e_lo = q[31:0];
            e_hi = r[31:0];
        end
        lat = zero ? 1 : (o ? 33 : 32);

        @(negedge clk);
        start = 1'b1;
        op    = o;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        op_a  = $urandom;
        op_b  = $urandom;
        check({tag, "/busy_on"}, 64'(busy), 64'd1);

        n = 0;
        while (n < 60 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (glitch && n == 10) begin
                start = 1'b1;
                op_a  = 32'd9;
                op    = 1'b1;
            end
            if (glitch && n == 11) start = 1'b0;
        end
        check({tag, "/latency"}, 64'(n), 64'(lat));
        check({tag, "/busy_done"}, 64'(busy), 64'd0);
        check({tag, "/div_zero"}, 64'(div_zero), 64'(zero));
        check({tag, "/hilo_write"}, 64'(hilo_write), 64'(!zero));
        check({tag, "/hi"}, 64'(result_hi), 64'(e_hi));
        check({tag, "/lo"}, 64'(result_lo), 64'(e_lo));
        m_hi = e_hi;
        m_lo = e_lo;

        if (poke) begin
            start = 1'b1;
            op    = 1'b0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "/done_end"}, 64'(done), 64'd0);
        check({tag, "/idle"}, 64'(busy), 64'd0);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, "/poke_drop"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int nd;
        logic        ro;
        logic [31:0] ra, rb;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/done", 64'(done), 64'd0);
        check("rst/hilo", 64'(hilo_write), 64'd0);
        check("rst/result", {result_hi, result_lo}, 64'd0);
        reset = 1'b0;

        do_op(1'b0, 32'd7, 32'hFFFFFFFD, "mul_7_m3", 1'b0, 1'b0);
        do_op(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2", 1'b0, 1'b0);
        do_op(1'b1, 32'h275, 32'h12, "div_prep", 1'b0, 1'b0);
        do_op(1'b1, 32'd5, 32'd0, "div_zero", 1'b0, 1'b0);
        do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_wrap", 1'b0, 1'b0);
        do_op(1'b0, 32'd3, 32'd4, "mul_glitch", 1'b1, 1'b0);
        do_op(1'b0, 32'h80000000, 32'h80000000, "mul_min", 1'b0, 1'b1);
        do_op(1'b1, 32'h80000000, 32'd7, "div_min", 1'b0, 1'b0);

        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort/busy", 64'(busy), 64'd0);
        check("abort/done", 64'(done), 64'd0);
        check("abort/result", {result_hi, result_lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("abort/no_done", 64'(nd), 64'd0);

        do_op(1'b0, 32'd2, 32'd2, "mul_2_2", 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($signed(8'($urandom)));
            if ($urandom_range(0, 3) == 0) rb = 32'($signed(4'($urandom)));
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            do_op(ro, ra, rb, $sformatf("rnd%0d", k), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
